// File: rtl/multi_button_debouncer.sv
// Multi-channel button debouncer: two-flop synchroniser, shared sample-tick
// prescaler, per-channel debounce counter and IDLE/HELD/LONG event FSM.
//
// state | meaning
// IDLE  | debounced level low, waiting for an accepted rise
// HELD  | debounced level high, counting ticks towards long-press
// LONG  | long-press reported, counting ticks between auto-repeats
module multi_button_debouncer #(
  parameter int NCH          = 4,
  parameter int TICK_DIV     = 50_000,
  parameter int DB_TICKS     = 10,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_in,
  input  logic [NCH-1:0] repeat_en,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_press,
  output logic [NCH-1:0] btn_release,
  output logic [NCH-1:0] btn_hold,
  output logic [NCH-1:0] btn_repeat
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int DBW  = $clog2(DB_TICKS + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0]  REP_LAST   = HW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [NCH-1:0] meta_q, sync_q;
  logic [PW-1:0]  presc_q;
  logic           tick;

  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] press_q, press_d;
  logic [NCH-1:0] release_q, release_d;
  logic [NCH-1:0] hold_q, hold_d;
  logic [NCH-1:0] repeat_q, repeat_d;
  logic [NCH-1:0] rise, fall;
  logic [DBW-1:0] db_q [NCH];
  logic [DBW-1:0] db_d [NCH];
  logic [HW-1:0]  hcnt_q [NCH];
  logic [HW-1:0]  hcnt_d [NCH];
  state_t         state_q [NCH];
  state_t         state_d [NCH];

  // Two-flop synchroniser for the raw pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_in;
      sync_q <= meta_q;
    end
  end

  // Free-running prescaler producing the shared sample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else if (presc_q == PRESC_LAST) presc_q <= '0;
    else presc_q <= presc_q + PW'(1);
  end

  assign tick = (presc_q == PRESC_LAST);

  // Per-channel debounce and event FSM next-state; everything advances on tick only
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    repeat_d  = '0;
    rise      = '0;
    fall      = '0;
    for (int i = 0; i < NCH; i++) begin
      db_d[i]    = db_q[i];
      hcnt_d[i]  = hcnt_q[i];
      state_d[i] = state_q[i];
      if (tick) begin
        if (sync_q[i] != level_q[i]) begin
          if (db_q[i] == DB_LAST) begin
            level_d[i] = sync_q[i];
            db_d[i]    = '0;
            rise[i]    = sync_q[i];
            fall[i]    = ~sync_q[i];
          end else begin
            db_d[i] = db_q[i] + DBW'(1);
          end
        end else begin
          db_d[i] = '0;
        end

        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i] = HELD;
              hcnt_d[i]  = '0;
              press_d[i] = 1'b1;
            end
          end
          HELD: begin
            // A fall on the same tick as the long-press threshold suppresses btn_hold
            if (fall[i]) begin
              state_d[i]   = IDLE;
              hcnt_d[i]    = '0;
              release_d[i] = 1'b1;
            end else if (hcnt_q[i] == HOLD_LAST) begin
              state_d[i] = LONG;
              hcnt_d[i]  = '0;
              hold_d[i]  = 1'b1;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
          end
          LONG: begin
            if (fall[i]) begin
              state_d[i]   = IDLE;
              hcnt_d[i]    = '0;
              release_d[i] = 1'b1;
            end else if (hcnt_q[i] == REP_LAST) begin
              // Period counter wraps even when repeat is disabled
              hcnt_d[i]   = '0;
              repeat_d[i] = repeat_en[i];
            end else begin
              hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            hcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Register per-channel state and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        db_q[i]    <= '0;
        hcnt_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < NCH; i++) begin
        db_q[i]    <= db_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_hold    = hold_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with a fast tick (TICK_DIV=4).
module tb_multi_button_debouncer;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] repeat_en;
  logic [1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;

  multi_button_debouncer #(
    .NCH(2), .TICK_DIV(4), .DB_TICKS(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_hold(btn_hold), .btn_repeat(btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since last reset release: ticks act on posedges where cyc is a multiple of 4
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_press[2], n_rel[2], n_hold[2], n_rep[2];
  int last_press[2], last_rel[2];
  int width_err = 0;
  logic [1:0] prev_p = '0, prev_r = '0, prev_h = '0, prev_q = '0;

  initial begin
    for (int c = 0; c < 2; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_hold[c] = 0; n_rep[c] = 0;
      last_press[c] = -1; last_rel[c] = -1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (btn_press[c])   begin n_press[c]++; last_press[c] = cyc; end
        if (btn_release[c]) begin n_rel[c]++;   last_rel[c]   = cyc; end
        if (btn_hold[c])    n_hold[c]++;
        if (btn_repeat[c])  n_rep[c]++;
      end
      if (|(btn_press & prev_p) || |(btn_release & prev_r) ||
          |(btn_hold & prev_h) || |(btn_repeat & prev_q)) width_err++;
      prev_p = btn_press; prev_r = btn_release; prev_h = btn_hold; prev_q = btn_repeat;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] btn;
    logic [1:0] rep;
    int         cycles;
    logic [1:0] lvl;
    int p0, p1, r0, r1, h0, h1, q0, q1;
  } vec_t;

  vec_t vecs [9];
  int s_p[2], s_r[2], s_h[2], s_q[2];

  task automatic snap();
    for (int c = 0; c < 2; c++) begin
      s_p[c] = n_press[c]; s_r[c] = n_rel[c]; s_h[c] = n_hold[c]; s_q[c] = n_rep[c];
    end
  endtask

  initial begin
    //             btn    rep   cyc  lvl   p0 p1 r0 r1 h0 h1 q0 q1
    vecs[0] = '{2'b00, 2'b00, 100, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{2'b01, 2'b01,  24, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{2'b01, 2'b01,  80, 2'b01, 0, 0, 0, 0, 1, 0, 9, 0};
    vecs[3] = '{2'b01, 2'b00,  40, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{2'b00, 2'b00,  40, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[5] = '{2'b01, 2'b00,  64, 2'b01, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[6] = '{2'b00, 2'b00,  40, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{2'b10, 2'b10,  24, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{2'b00, 2'b00,  40, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0};

    rst = 1'b1; btn_in = '0; repeat_en = '0;
    run(3);
    chk("reset_outputs", int'({btn_level, btn_press, btn_release, btn_hold, btn_repeat}), 0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      snap();
      btn_in = vecs[v].btn;
      repeat_en = vecs[v].rep;
      run(vecs[v].cycles);
      chk($sformatf("v%0d_level", v),    int'(btn_level), int'(vecs[v].lvl));
      chk($sformatf("v%0d_press0", v),   n_press[0] - s_p[0], vecs[v].p0);
      chk($sformatf("v%0d_press1", v),   n_press[1] - s_p[1], vecs[v].p1);
      chk($sformatf("v%0d_release0", v), n_rel[0] - s_r[0],   vecs[v].r0);
      chk($sformatf("v%0d_release1", v), n_rel[1] - s_r[1],   vecs[v].r1);
      chk($sformatf("v%0d_hold0", v),    n_hold[0] - s_h[0],  vecs[v].h0);
      chk($sformatf("v%0d_hold1", v),    n_hold[1] - s_h[1],  vecs[v].h1);
      chk($sformatf("v%0d_repeat0", v),  n_rep[0] - s_q[0],   vecs[v].q0);
      chk($sformatf("v%0d_repeat1", v),  n_rep[1] - s_q[1],   vecs[v].q1);
    end

    // Clean press at cyc 452: latency must land in 11..15 cycles
    chk("s1_start_cyc", cyc, 452);
    snap();
    btn_in = 2'b01;
    run(16);
    chk("s1_press0", n_press[0] - s_p[0], 1);
    chk("s1_press1_silent", n_press[1] - s_p[1], 0);
    checks++;
    if (last_press[0] - 452 < 11 || last_press[0] - 452 > 15) begin
      errors++;
      $display("FAIL s1_latency: got %0d cycles, expected 11..15", last_press[0] - 452);
    end
    btn_in = 2'b00;
    run(32);
    chk("s1_release0", n_rel[0] - s_r[0], 1);
    chk("s1_level", int'(btn_level), 0);

    // Bounce every 5 cycles for 40 cycles, then stable high
    snap();
    for (int k = 0; k < 8; k++) begin
      btn_in = (k % 2 == 0) ? 2'b01 : 2'b00;
      run(5);
    end
    chk("s2_no_press_bounce", n_press[0] - s_p[0], 0);
    chk("s2_level_bounce", int'(btn_level), 0);
    btn_in = 2'b01;
    run(20);
    chk("s2_press_once", n_press[0] - s_p[0], 1);
    chk("s2_press_cyc", last_press[0], 552);

    // Release accepted on the very tick the long-press would fire
    snap();
    btn_in = 2'b00;
    run(40);
    chk("s3_release", n_rel[0] - s_r[0], 1);
    chk("s3_release_cyc", last_rel[0], 572);
    chk("s3_no_hold", n_hold[0] - s_h[0], 0);
    chk("s3_no_repeat", n_rep[0] - s_q[0], 0);
    chk("s3_level", int'(btn_level), 0);

    // Both channels pressed together, then reset during long-press
    snap();
    btn_in = 2'b11; repeat_en = 2'b11;
    run(20);
    chk("s4_press0", n_press[0] - s_p[0], 1);
    chk("s4_press1", n_press[1] - s_p[1], 1);
    chk("s4_press0_cyc", last_press[0], 612);
    chk("s4_press1_cyc", last_press[1], 612);
    run(16);
    chk("s4_hold0", n_hold[0] - s_h[0], 1);
    chk("s4_hold1", n_hold[1] - s_h[1], 1);
    chk("s4_level_pre_rst", int'(btn_level), 3);
    snap();
    rst = 1'b1;
    #1;
    chk("s4_async_clear", int'({btn_level, btn_press, btn_release, btn_hold, btn_repeat}), 0);
    run(3);
    rst = 1'b0;
    run(20);
    chk("s4_no_release0", n_rel[0] - s_r[0], 0);
    chk("s4_no_release1", n_rel[1] - s_r[1], 0);
    chk("s4_repress0", n_press[0] - s_p[0], 1);
    chk("s4_repress1", n_press[1] - s_p[1], 1);
    chk("s4_repress0_cyc", last_press[0], 12);
    chk("s4_repress1_cyc", last_press[1], 12);
    chk("s4_level_post_rst", int'(btn_level), 3);

    chk("pulse_width", width_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
